// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit and receive sides.
//   uart_state_t         - serialiser FSM state encoding
//   DEFAULT_DELAY_FRAMES - clock cycles per bit at 27 MHz / 115200 baud
//   CNT_W                - width of the per-bit cycle counter
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_t;

   localparam int DEFAULT_DELAY_FRAMES = 234;
   localparam int CNT_W                = 13;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: byte producer handshake into the UART transmitter.
//   tx_data  - byte offered by the producer
//   tx_valid - producer offers tx_data this cycle
//   tx_ready - transmitter FIFO can accept a byte
// master = producer side, slave = transmitter side.
interface uart_tx_fifo_if;

   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous active-high reset.
//   clk, rst    - clock, synchronous reset
//   push, din   - write request and data (ignored while full)
//   pop, dout   - read request; dout shows the head entry straight from storage
//   full, empty - status derived from the occupancy count
//   count       - number of stored entries
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [WIDTH-1:0]  din,
   output logic [WIDTH-1:0]  dout,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count
);

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              do_push;
   logic              do_pop;

   // Status comes from registered count only, so a pop on a full FIFO
   // frees the slot for the following cycle, not the current one.
   assign full    = (count == (ADDR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered 8N1 UART transmitter, LSB first.
//   clk, rst   - system clock, synchronous active-high reset
//   tx_bus     - producer handshake (slave side)
//   uart_tx    - serial line, idle high, driven from a register
//   busy       - frame in flight or bytes queued
//   fifo_count - bytes queued, not counting the one being shifted
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DELAY_FRAMES = DEFAULT_DELAY_FRAMES,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   uart_tx_fifo_if.slave                 tx_bus,
   output logic                          uart_tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DELAY_FRAMES - 1);

   uart_state_t      state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       idx, idx_nxt;
   logic [7:0]       shift, shift_nxt;
   logic             line_nxt;
   logic             pop;
   logic             full, empty;
   logic [7:0]       head;
   logic             done;

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_bus.tx_valid),
      .pop   (pop),
      .din   (tx_bus.tx_data),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   assign tx_bus.tx_ready = !full;
   assign busy            = (state != IDLE) || (fifo_count != '0);
   assign done            = (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         idx     <= '0;
         shift   <= '0;
         uart_tx <= 1'b1;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         idx     <= idx_nxt;
         shift   <= shift_nxt;
         uart_tx <= line_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + CNT_W'(1);
      idx_nxt   = idx;
      shift_nxt = shift;
      line_nxt  = uart_tx;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt  = '0;
            line_nxt = 1'b1;
            if (!empty) begin
               pop       = 1'b1;
               shift_nxt = head;
               line_nxt  = 1'b0;
               state_nxt = START;
            end
         end
         START: begin
            if (done) begin
               cnt_nxt   = '0;
               idx_nxt   = '0;
               line_nxt  = shift[0];
               state_nxt = DATA;
            end
         end
         DATA: begin
            if (done) begin
               cnt_nxt = '0;
               if (idx == 3'd7) begin
                  line_nxt  = 1'b1;
                  state_nxt = STOP;
               end else begin
                  // shift[1] is the next bit once the register shifts right
                  shift_nxt = shift >> 1;
                  line_nxt  = shift[1];
                  idx_nxt   = idx + 3'd1;
               end
            end
         end
         STOP: begin
            if (done) begin
               cnt_nxt = '0;
               if (!empty) begin
                  // chain straight into the next start bit, no idle gap
                  pop       = 1'b1;
                  shift_nxt = head;
                  line_nxt  = 1'b0;
                  state_nxt = START;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo.
// dut1 runs with 4 cycles/bit and a 4-deep FIFO against a frame-level model;
// dut2 runs at default parameters for timing and loopback decoding.
module tb_uart_tx_fifo;

   localparam int D   = 4;
   localparam int DEP = 4;
   localparam int DD  = 234;
   localparam logic [9:0] F55 = 10'b1010101010;  // start, 1,0,1,0,1,0,1,0, stop

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx1, busy1, tx2, busy2;
   logic [2:0] cnt1;
   logic [4:0] cnt2;

   uart_tx_fifo_if bus1 ();
   uart_tx_fifo_if bus2 ();

   uart_tx_fifo #(.DELAY_FRAMES(D), .FIFO_DEPTH(DEP)) dut1 (
      .clk        (clk),
      .rst        (rst),
      .tx_bus     (bus1.slave),
      .uart_tx    (tx1),
      .busy       (busy1),
      .fifo_count (cnt1)
   );

   uart_tx_fifo dut2 (
      .clk        (clk),
      .rst        (rst),
      .tx_bus     (bus2.slave),
      .uart_tx    (tx2),
      .busy       (busy2),
      .fifo_count (cnt2)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // ---------------- frame-level model of dut1 ----------------
   logic [7:0] mq[$];
   bit         m_in   = 1'b0;
   int         m_t    = 0;
   logic [7:0] m_cur  = '0;
   bit         model_on = 1'b0;

   task automatic model_step();
      bit do_push, end_frame, can_start;
      if (rst) begin
         mq.delete();
         m_in = 1'b0;
         m_t  = 0;
         return;
      end
      do_push   = (bus1.tx_valid === 1'b1) && (mq.size() < DEP);
      end_frame = m_in && (m_t == 10*D - 1);
      can_start = (!m_in || end_frame) && (mq.size() > 0);
      if (m_in) m_t++;
      if (end_frame) m_in = 1'b0;
      if (can_start) begin
         m_cur = mq.pop_front();
         m_in  = 1'b1;
         m_t   = 0;
      end
      if (do_push) mq.push_back(bus1.tx_data);
   endtask

   function automatic logic m_line();
      logic [9:0] f;
      if (!m_in) return 1'b1;
      f = {1'b1, m_cur, 1'b0};
      return f[m_t / D];
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (model_on) begin
         chk("m_uart_tx",    tx1,            m_line());
         chk("m_busy",       busy1,          m_in || (mq.size() != 0));
         chk("m_tx_ready",   bus1.tx_ready,  mq.size() < DEP);
         chk("m_fifo_count", cnt1,           mq.size());
      end
   end

   // ---------------- directed helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle1();
      int n = 0;
      while ((busy1 !== 1'b0 || tx1 !== 1'b1) && n < 3000) begin
         tick();
         n++;
      end
      chk("idle_timeout", n < 3000, 1);
      tick();
   endtask

   // k = 0 is the sample after the edge that launches the first start bit
   task automatic expect_frames(input logic [7:0] b[8], input int n, input int k0);
      logic [9:0] f;
      for (int k = k0; k < 10*D*n + 3; k++) begin
         tick();
         if (k < 10*D*n) begin
            f = {1'b1, b[k/(10*D)], 1'b0};
            chk("line", tx1, f[(k % (10*D)) / D]);
         end else begin
            chk("line_idle", tx1, 1);
         end
         chk("busy_span", busy1, k < 10*D*n);
      end
   endtask

   initial begin
      int         k;
      logic [2:0] peak;
      logic [7:0] rx;
      logic [9:0] f;

      bus1.tx_valid = 1'b0;
      bus1.tx_data  = '0;
      bus2.tx_valid = 1'b0;
      bus2.tx_data  = '0;
      rst = 1'b1;
      tick();
      model_on = 1'b1;
      tick();
      rst = 1'b0;
      tick();

      // reset state
      chk("rst_uart_tx",  tx1,           1);
      chk("rst_busy",     busy1,         0);
      chk("rst_count",    cnt1,          0);
      chk("rst_ready",    bus1.tx_ready, 1);
      chk("rst_uart_tx2", tx2,           1);
      chk("rst_busy2",    busy2,         0);

      // 1: single byte 0x55, literal waveform
      bus1.tx_valid = 1'b1;
      bus1.tx_data  = 8'h55;
      tick();
      bus1.tx_valid = 1'b0;
      bus1.tx_data  = 8'h00;
      chk("t1_busy_queued", busy1, 1);
      for (int j = 0; j < 43; j++) begin
         tick();
         chk("t1_line", tx1,   (j < 40) ? F55[j/4] : 1'b1);
         chk("t1_busy", busy1, j < 40);
      end

      // 2: back-to-back frames
      wait_idle1();
      bus1.tx_valid = 1'b1;
      bus1.tx_data  = 8'hA5;
      tick();
      bus1.tx_data  = 8'h3C;
      tick();
      bus1.tx_valid = 1'b0;
      expect_frames('{8'hA5, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 1);

      // 3: overfill a 4-deep FIFO; 0x06 must be dropped
      wait_idle1();
      peak = '0;
      bus1.tx_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus1.tx_data = 8'(i + 1);
         tick();
         if (cnt1 > peak) peak = cnt1;
         if (i == 4) chk("t3_ready_full", bus1.tx_ready, 0);
      end
      bus1.tx_valid = 1'b0;
      chk("t3_peak", peak, 4);
      expect_frames('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00, 8'h00, 8'h00}, 5, 5);

      // 4: reset during data bit 3 of 0xFF with two bytes queued
      wait_idle1();
      bus1.tx_valid = 1'b1;
      bus1.tx_data  = 8'hFF;
      tick();
      bus1.tx_data  = 8'h11;
      tick();
      bus1.tx_data  = 8'h22;
      tick();
      bus1.tx_valid = 1'b0;
      k = 1;
      chk("t4_queued", cnt1, 2);
      while (k < 17) begin
         tick();
         k++;
      end
      chk("t4_bit3", tx1, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t4_uart_tx", tx1,           1);
      chk("t4_count",   cnt1,          0);
      chk("t4_busy",    busy1,         0);
      chk("t4_ready",   bus1.tx_ready, 1);
      for (int j = 0; j < 50; j++) begin
         tick();
         chk("t4_quiet_line", tx1,   1);
         chk("t4_quiet_busy", busy1, 0);
      end

      // 5: push on the STOP->START edge with two bytes queued
      wait_idle1();
      bus1.tx_valid = 1'b1;
      bus1.tx_data  = 8'h10;
      tick();
      bus1.tx_data  = 8'h20;
      tick();
      bus1.tx_data  = 8'h30;
      tick();
      bus1.tx_valid = 1'b0;
      k = 1;
      while (k < 39) begin
         tick();
         k++;
      end
      chk("t5_count_before", cnt1, 2);
      bus1.tx_valid = 1'b1;
      bus1.tx_data  = 8'h7E;
      tick();
      bus1.tx_valid = 1'b0;
      chk("t5_count_after", cnt1, 2);
      chk("t5_restart",     tx1,  0);
      expect_frames('{8'h10, 8'h20, 8'h30, 8'h7E, 8'h00, 8'h00, 8'h00, 8'h00}, 4, 41);

      // 6: default parameters, 0x41, bit timing and decoded byte
      bus2.tx_valid = 1'b1;
      bus2.tx_data  = 8'h41;
      tick();
      bus2.tx_valid = 1'b0;
      bus2.tx_data  = 8'h00;
      rx = '0;
      f  = {1'b1, 8'h41, 1'b0};
      for (int j = 0; j < 10*DD + 2; j++) begin
         tick();
         if (j < 10*DD) begin
            if ((j % DD) == 0 || (j % DD) == DD - 1)
               chk("t6_line", tx2, f[j/DD]);
            if ((j % DD) == DD/2 && j/DD >= 1 && j/DD <= 8)
               rx[j/DD - 1] = tx2;
         end
         if (j == 10*DD - 1) chk("t6_busy_last", busy2, 1);
         if (j == 10*DD)     chk("t6_busy_done", busy2, 0);
      end
      chk("t6_loopback", rx,   8'h41);
      chk("t6_count",    cnt2, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
